// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle control unit and its datapath.
// Latency: wires only, no storage.
// Backpressure: mem_ready from the memory side stalls the controller in its access states.
interface multicycle_control_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] instr;
    logic                  EQ;
    logic                  LT;
    logic                  LTU;
    logic                  mem_ready;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  IRWrite;
    logic [1:0]            ResultSrc;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [3:0]            ALUctrl;
    logic [2:0]            ImmSrc;
    logic                  RegWrite;
    logic                  illegal;

    // Controller side: consumes IR/flags/ready, drives the datapath controls.
    modport master (
        input  instr, EQ, LT, LTU, mem_ready,
        output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
        output ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, RegWrite, illegal
    );

    // Datapath side.
    modport slave (
        output instr, EQ, LT, LTU, mem_ready,
        input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
        input  ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, RegWrite, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// RV32I multicycle control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: 3 (branch), 4 (ALU/jump/store), 5 (load) cycles plus memory wait cycles.
// Backpressure: holds FETCH/MEMREAD/MEMWRITE with requests stable until mem_ready=1.
module multicycle_control (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_AUIPC    = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_illegal;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_f7b5;
    logic       w_taken;
    logic [3:0] w_alu_op;

    assign w_opcode    = bus.instr[6:0];
    assign w_funct3    = bus.instr[14:12];
    assign w_f7b5      = bus.instr[30];
    assign bus.illegal = r_illegal;

    // State register and sticky illegal flag; illegal rises together with entry to TRAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP) r_illegal <= 1'b1;
        end
    end

    // Next-state selection: opcode dispatch in DECODE, memory-ready holds, branch funct3 check.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_opcode)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100111:             w_next = S_JALR;
                    7'b0110111:             w_next = S_LUI;
                    7'b0010111:             w_next = S_AUIPC;
                    7'b1110011:             w_next = S_FETCH;
                    default:                w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = bus.instr[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI, S_AUIPC:
                        w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = (w_funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // ALU operation from funct3/funct7; immediates only honour funct7[5] for the right shift.
    always_comb begin
        w_alu_op = 4'b0000;
        case (w_funct3)
            3'b000:  w_alu_op = (w_f7b5 && r_state == S_EXECR) ? 4'b0001 : 4'b0000;
            3'b001:  w_alu_op = 4'b0111;
            3'b010:  w_alu_op = 4'b0101;
            3'b011:  w_alu_op = 4'b0110;
            3'b100:  w_alu_op = 4'b0100;
            3'b101:  w_alu_op = w_f7b5 ? 4'b1010 : 4'b1001;
            3'b110:  w_alu_op = 4'b0011;
            default: w_alu_op = 4'b0010;
        endcase
    end

    // Branch condition from the compare flags.
    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = bus.EQ;
            3'b001:  w_taken = !bus.EQ;
            3'b100:  w_taken = bus.LT;
            3'b101:  w_taken = !bus.LT;
            3'b110:  w_taken = bus.LTU;
            3'b111:  w_taken = !bus.LTU;
            default: w_taken = 1'b0;
        endcase
    end

    // Moore control outputs per state; every write/request enable is forced low while rst is high.
    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ALUctrl   = 4'b0000;
        bus.ImmSrc    = 3'b000;
        bus.RegWrite  = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.MemRead   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = 3'b010;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = bus.instr[5] ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                bus.AdrSrc  = 1'b1;
                bus.MemRead = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUctrl = w_alu_op;
            end
            S_EXECI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUctrl = w_alu_op;
            end
            S_ALUWB: bus.RegWrite = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUctrl = 4'b0001;
                bus.PCWrite = w_taken;
            end
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.ImmSrc  = 3'b100;
                bus.PCWrite = 1'b1;
            end
            S_JALR: begin
                bus.ALUSrcA   = 2'b10;
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = 1'b1;
            end
            S_LUI: begin
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = 3'b011;
                bus.ALUctrl = 4'b1000;
            end
            S_AUIPC: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = 3'b011;
            end
            default: ;
        endcase
        if (rst) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.MemRead  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.RegWrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected control sequences vs. the DUT.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
// Memory waits are injected randomly (or fixed) wherever the controller requests memory.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if #(.DATA_WIDTH(32)) bus ();
    multicycle_control dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       pcw, adr, mr, mw, irw;
        logic [1:0] res, sa, sb;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       rw, ill;
    } ctl_t;

    typedef struct {
        ctl_t go;
        ctl_t hold;
        bit   waits;
    } step_t;

    step_t steps[$];
    bit    exp_trap;

    localparam logic [6:0] OPS [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63,
                                        7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t observe();
        ctl_t c;
        c.pcw = bus.PCWrite;   c.adr = bus.AdrSrc;  c.mr  = bus.MemRead;
        c.mw  = bus.MemWrite;  c.irw = bus.IRWrite; c.res = bus.ResultSrc;
        c.sa  = bus.ALUSrcA;   c.sb  = bus.ALUSrcB; c.alu = bus.ALUctrl;
        c.imm = bus.ImmSrc;    c.rw  = bus.RegWrite; c.ill = bus.illegal;
        return c;
    endfunction

    function automatic ctl_t mk(input logic pcw, input logic adr, input logic mr,
                                input logic mw, input logic irw, input logic [1:0] res,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic [3:0] alu, input logic [2:0] imm, input logic rw);
        ctl_t c;
        c.pcw = pcw; c.adr = adr; c.mr = mr; c.mw = mw; c.irw = irw; c.res = res;
        c.sa = sa; c.sb = sb; c.alu = alu; c.imm = imm; c.rw = rw; c.ill = 1'b0;
        return c;
    endfunction

    function automatic void push(input ctl_t go, input ctl_t hold, input bit w);
        step_t s;
        s.go = go; s.hold = hold; s.waits = w;
        steps.push_back(s);
    endfunction

    // Mnemonic-level ALU operation for register (is_r) and immediate forms.
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input bit is_r);
        logic [3:0] tab [8];
        tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd9, 4'd3, 4'd2}; // add sll slt sltu xor srl or and
        if (f3 == 3'd0 && alt && is_r) return 4'd1;                // sub
        if (f3 == 3'd5 && alt) return 4'd10;                       // sra/srai
        return tab[f3];
    endfunction

    function automatic bit branch_taken(input logic [2:0] f3, input logic eq, input logic lt,
                                        input logic ltu);
        case (f3)
            3'd0: return eq;          // beq
            3'd1: return !eq;         // bne
            3'd4: return lt;          // blt
            3'd5: return !lt;         // bge
            3'd6: return ltu;         // bltu
            3'd7: return !ltu;        // bgeu
            default: return 1'b0;
        endcase
    endfunction

    // Expected per-cycle control words of one instruction.
    function automatic void build(input logic [31:0] ins, input logic eq, input logic lt,
                                  input logic ltu);
        logic [6:0] op;
        logic [2:0] f3;
        ctl_t       wb;
        op = ins[6:0];
        f3 = ins[14:12];
        wb = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 1'b1);
        steps.delete();
        exp_trap = 1'b0;
        push(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 4'd0, 3'd0, 1'b0),
             mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 4'd0, 3'd0, 1'b0), 1'b1);
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 4'd0, 3'd2, 1'b0), '0, 1'b0);
        case (op)
            7'h03: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 4'd0, 3'd0, 1'b0), '0, 1'b0);
                push(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 1'b0),
                     mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 1'b0), 1'b1);
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 4'd0, 3'd0, 1'b1), '0, 1'b0);
            end
            7'h23: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 4'd0, 3'd1, 1'b0), '0, 1'b0);
                push(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 1'b0),
                     mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 1'b0), 1'b1);
            end
            7'h33: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, alu_of(f3, ins[30], 1'b1),
                        3'd0, 1'b0), '0, 1'b0);
                push(wb, '0, 1'b0);
            end
            7'h13: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, alu_of(f3, ins[30], 1'b0),
                        3'd0, 1'b0), '0, 1'b0);
                push(wb, '0, 1'b0);
            end
            7'h63: begin
                push(mk(branch_taken(f3, eq, lt, ltu), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0,
                        4'd1, 3'd0, 1'b0), '0, 1'b0);
                exp_trap = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h6F: begin
                push(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 4'd0, 3'd4, 1'b0), '0, 1'b0);
                push(wb, '0, 1'b0);
            end
            7'h67: begin
                push(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd1, 4'd0, 3'd0, 1'b0), '0, 1'b0);
                push(wb, '0, 1'b0);
            end
            7'h37: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 4'd8, 3'd3, 1'b0), '0, 1'b0);
                push(wb, '0, 1'b0);
            end
            7'h17: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 4'd0, 3'd3, 1'b0), '0, 1'b0);
                push(wb, '0, 1'b0);
            end
            7'h73: ;
            default: exp_trap = 1'b1;
        endcase
    endfunction

    // Reset for one cycle: no enable may be seen while rst is high; illegal clears.
    task automatic do_reset();
        ctl_t c;
        rst = 1'b1;
        bus.mem_ready = 1'($urandom);
        #1;
        c = observe();
        check("rst_enables", {27'd0, c.pcw, c.irw, c.mr, c.mw, c.rw}, 32'd0);
        @(negedge clk);
        #1;
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        rst = 1'b0;
    endtask

    // waits<0: random wait cycles; flags<0: random {EQ,LT,LTU}; abort_at>=0: reset at that step.
    task automatic run(input logic [31:0] ins, input int waits, input int flags, input int abort_at);
        logic eq, lt, ltu;
        int   w;
        ctl_t trap_c;
        if (flags < 0) {eq, lt, ltu} = 3'($urandom);
        else           {eq, lt, ltu} = 3'(flags);
        bus.instr = ins; bus.EQ = eq; bus.LT = lt; bus.LTU = ltu;
        build(ins, eq, lt, ltu);
        for (int i = 0; i < steps.size(); i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            if (steps[i].waits) begin
                if (waits >= 0) w = waits;
                else w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                for (int k = 0; k < w; k++) begin
                    bus.mem_ready = 1'b0;
                    #1 check($sformatf("ins%h_step%0d_wait%0d", ins, i, k), 32'(observe()),
                             32'(steps[i].hold));
                    @(negedge clk);
                end
                bus.mem_ready = 1'b1;
            end else begin
                bus.mem_ready = 1'($urandom);
            end
            #1 check($sformatf("ins%h_step%0d", ins, i), 32'(observe()), 32'(steps[i].go));
            @(negedge clk);
        end
        if (exp_trap) begin
            trap_c = '0;
            trap_c.ill = 1'b1;
            for (int k = 0; k < 10; k++) begin
                bus.mem_ready = 1'($urandom);
                #1 check($sformatf("ins%h_trap%0d", ins, k), 32'(observe()), 32'(trap_c));
                @(negedge clk);
            end
            do_reset();
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        for (int i = 0; i < 10; i++) if (OPS[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [31:0] r;
        int          sel;
        rst = 1'b1;
        bus.instr = '0; bus.EQ = 1'b0; bus.LT = 1'b0; bus.LTU = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        do_reset();
        run(32'h002081B3, 0, -1, -1);   // add x3,x1,x2
        run(32'h00012183, 3, -1, -1);   // lw, three wait cycles per access
        run(32'h0030A223, 0, -1, -1);   // sw
        run(32'h0020C463, 0, 2, -1);    // blt with LT=1: taken
        run(32'h0020D463, 0, 2, -1);    // bge with LT=1: not taken
        run(32'hFFFFFFFF, 0, -1, -1);   // illegal opcode
        run(32'h4020D193, 0, -1, -1);   // srai
        run(32'h40209193, 0, -1, -1);   // slli with funct7=0x20
        run(32'hFFF08093, 0, -1, -1);   // addi with imm[10]=1 stays add
        run(32'h40208133, 0, -1, -1);   // sub
        run(32'h008000EF, 0, -1, -1);   // jal
        run(32'h000080E7, 0, -1, -1);   // jalr
        run(32'h123452B7, 0, -1, -1);   // lui
        run(32'h00001297, 0, -1, -1);   // auipc
        run(32'h00000073, 0, -1, -1);   // ecall as nop
        run(32'h0020A463, 0, -1, -1);   // branch funct3=010 traps
        run(32'h00012183, 2, -1, 3);    // lw abandoned by reset in its memory read
        run(32'h002081B3, 0, -1, 3);    // add abandoned by reset in writeback
        run(32'h0030A223, 1, -1, 3);    // sw abandoned by reset in its memory write
        for (int n = 0; n < 250; n++) begin
            r   = $urandom;
            sel = int'($urandom_range(0, 10));
            if (sel == 10) begin
                while (is_legal(r[6:0])) r = $urandom;
            end else begin
                r[6:0] = OPS[sel];
            end
            run(r, -1, -1, ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multicycle control unit for the RV32I core. It replaces the single-cycle combinational decoder with a state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It stalls on a memory-ready handshake, resolves all six branch conditions, and flags illegal opcodes. It sits between the instruction register / ALU flags and the shared-memory multicycle datapath.

## Interface
- DATA_WIDTH, 32: instruction width; only bits [31:0] are decoded.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- instr  in  DATA_WIDTH  current instruction from the IR; only valid after FETCH completes.
- EQ, LT, LTU  in  1 each  ALU compare flags for rs1 vs rs2: equal, signed less-than, unsigned less-than.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  load the PC.
- AdrSrc  out  1  memory address source: 0 = PC, 1 = ALU result register.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  latch the fetched word into the IR and the old PC.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- ALUctrl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 pass B, 1001 srl, 1010 sra.
- ImmSrc  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- RegWrite  out  1  register-file write enable.
- illegal  out  1  sticky illegal-instruction flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP.
- FETCH: AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUctrl=add, ResultSrc=10.
  - While mem_ready=0: stay in FETCH; PCWrite=0, IRWrite=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=B, ALUctrl=add, so ALUOut holds the branch target. Next state by opcode:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 1100111 -> JALR.
  - 0110111 -> LUI.
  - 0010111 -> AUIPC.
  - 1110011 -> FETCH (ecall/ebreak treated as nop).
  - Anything else -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUctrl=add; ImmSrc=I for loads, S for stores. Loads go to MEMREAD, stores go to MEMWRITE.
- MEMREAD: AdrSrc=1, MemRead=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. Holds until mem_ready=1, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. ALUctrl comes from funct3/funct7; funct7 bit 5 selects sub and sra. Then ALUWB.
- EXECI: as EXECR but ALUSrcB=01, ImmSrc=I, and funct7 bit 5 is honoured only for funct3=101. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUctrl=sub, ResultSrc=00. PCWrite is set from the flags per funct3:
  - 000: EQ; 001: !EQ.
  - 100: LT; 101: !LT.
  - 110: LTU; 111: !LTU.
  - Funct3 010/011 -> TRAP instead.
  - Otherwise next state is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUctrl=add, ImmSrc=J, PCWrite=1, ResultSrc=00. Then ALUWB, which writes old PC + 4 into rd. The datapath loads PC from old PC + J-imm via its own adder.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, ResultSrc=10, PCWrite=1. Then ALUWB.
- LUI: ALUSrcB=01, ImmSrc=U, ALUctrl=pass B, then ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=U, ALUctrl=add, then ALUWB.
- TRAP: illegal=1 and latched; all enables are 0. TRAP is absorbing and is left only by rst.
- All unlisted outputs are 0 in every state.

## Timing
- Outputs are a Moore function of state, plus instr and flags in BRANCH/EXEC. The state register updates on the rising edge of clk.
- Reset: state=FETCH, illegal=0. All enables (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) are 0 during the reset cycle.
- Asserting rst mid-instruction abandons it; no write enable is asserted in the cycle rst is high.
- Cycle counts with zero wait states:
  - lw: 5.
  - sw: 4.
  - R/I-type, lui, auipc: 4.
  - Branch: 3.
  - jal, jalr: 4.
  - Each wait cycle (mem_ready=0) in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MemRead/MemWrite stay asserted and stable until the cycle in which mem_ready=1. mem_ready seen in any other state is ignored.

## Test plan
- Reset, then mem_ready=1, instr=add x3,x1,x2 (0x002081B3): states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4; ALUctrl=0000 in EXECR.
- lw 0x00012183 with mem_ready held low 3 cycles in MEMREAD: MemRead stays high for 4 cycles; MEMWB follows with ResultSrc=01 and RegWrite=1.
- sw 0x0030A223: ImmSrc=001 in MEMADR; MemWrite=1 for exactly 1 cycle; RegWrite never asserted.
- Branches 0x0020C463 (blt) and 0x0020D463 (bge) with LT=1: PCWrite=1 for blt and 0 for bge, in BRANCH; 3 cycles each.
- instr=0xFFFFFFFF: reaches TRAP after DECODE; illegal=1 held for 10 cycles; rst returns to FETCH with illegal=0.
- srai 0x4020D193: ALUctrl=1010 in EXECI; slli with funct7=0x20 gives ALUctrl=0111.
